dmem_ctrl: RTL and testbench

Data-memory access controller for the MEM stage of the RISC-V pipeline. It takes the MEM-stage load/store request, generates the word address, byte enables and lane-shifted store data, and runs the request/grant/response handshake with the data SRAM. It stalls the pipeline until the access retires, then presents the raw read word, load type and byte offset to the downstream load-alignment stage.

---
 rtl/lsu_pkg.sv | 13 +
 rtl/store_lane.sv | 20 ++
 rtl/dmem_ctrl.sv | 98 +++++++++
 tb/tb_dmem_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 encodings, FSM states and timeout counter width for the data-memory path
package lsu_pkg;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
endpackage

// File: rtl/store_lane.sv
// store_lane: access-width decode giving byte enables, lane-replicated store data and misalignment
module store_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_shifted,
  output logic        misaligned
);
  logic is_b, is_h;
  always_comb begin
    is_b = funct3[1:0] == SB[1:0];
    is_h = funct3[1:0] == SH[1:0];
    be = is_b ? 4'b0001 << offset : is_h ? 4'b0011 << offset : 4'b1111;
    wdata_shifted = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
    misaligned = is_h ? offset[0] : !is_b && offset != 2'b00;
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage load/store controller running the SRAM request/grant/response handshake
module dmem_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_M,
  input  logic        we_M,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] addr_M,
  input  logic [31:0] wdata_M,
  output logic        stall_M,
  output logic        done,
  output logic        misalign_exc,
  output logic        bus_err,
  output logic [31:0] rdata_o,
  output logic [2:0]  load_sel_o,
  output logic [1:0]  offset_o,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  state_t state, next;
  logic [CNT_W-1:0] cnt;
  logic [3:0] lane_be;
  logic [31:0] lane_wdata;
  logic lane_mis, mis_q, err_q, accept, busy, tmo, stuck;
  store_lane u_lane (
    .funct3(funct3_M),
    .offset(addr_M[1:0]),
    .wdata(wdata_M),
    .be(lane_be),
    .wdata_shifted(lane_wdata),
    .misaligned(lane_mis)
  );
  assign accept = state == IDLE && req_valid_M;
  assign busy = state == REQ || state == WAIT;
  assign tmo = cnt >= CNT_W'(TIMEOUT - 1);
  assign stuck = tmo && (state == REQ ? !mem_gnt : state == WAIT && !mem_rvalid);
  assign done = state == DONE;
  assign misalign_exc = done && mis_q;
  assign bus_err = done && err_q;
  assign mem_req = state == REQ;
  assign stall_M = req_valid_M && !done;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = req_valid_M ? (lane_mis ? DONE : REQ) : IDLE;
      REQ: next = mem_gnt ? (mem_we ? DONE : WAIT) : tmo ? DONE : REQ;
      WAIT: next = mem_rvalid || tmo ? DONE : WAIT;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      mis_q <= 1'b0;
      err_q <= 1'b0;
      rdata_o <= '0;
      load_sel_o <= '0;
      offset_o <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_wdata <= '0;
    end else begin
      if (accept) begin
        cnt <= '0;
        mis_q <= lane_mis;
        err_q <= 1'b0;
        if (!lane_mis) begin
          mem_we <= we_M;
          mem_addr <= {addr_M[31:2], 2'b00};
          mem_be <= we_M ? lane_be : 4'b1111;
          mem_wdata <= lane_wdata;
          if (!we_M) begin
            load_sel_o <= funct3_M;
            offset_o <= addr_M[1:0];
          end
        end
      end
      if (busy) cnt <= cnt + 1'b1;
      if (stuck) err_q <= 1'b1;
      if (state == WAIT && mem_rvalid) rdata_o <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scenario and randomized checks of dmem_ctrl against a transaction-level model
module tb_dmem_ctrl;
  localparam int TMO = 4;
  logic clk, rst, req_valid_M, we_M;
  logic [2:0] funct3_M;
  logic [31:0] addr_M, wdata_M;
  logic stall_M, done, misalign_exc, bus_err;
  logic [31:0] rdata_o;
  logic [2:0] load_sel_o;
  logic [1:0] offset_o;
  logic mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_be;
  int vectors = 0, miscompares = 0;
  logic [31:0] exp_rdata;
  logic [2:0] exp_sel;
  logic [1:0] exp_off;
  int done_at, reqcnt;
  logic [3:0] be_seen;
  logic [31:0] wd_seen;

  dmem_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid_M(req_valid_M), .we_M(we_M), .funct3_M(funct3_M),
    .addr_M(addr_M), .wdata_M(wdata_M), .stall_M(stall_M), .done(done),
    .misalign_exc(misalign_exc), .bus_err(bus_err), .rdata_o(rdata_o),
    .load_sel_o(load_sel_o), .offset_o(offset_o), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int gd, input int rvd, input logic [31:0] rd,
                        input bit noise);
    int size, g, p, reqend, done_n;
    bit mis, err, inreq, inwait;
    logic [3:0] ebe;
    logic [31:0] ewd;
    size = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    mis = (int'(addr[1:0]) % size) != 0;
    ebe = we ? 4'(((1 << size) - 1) << addr[1:0]) : 4'hf;
    ewd = size == 1 ? wd[7:0] * 32'h0101_0101 : size == 2 ? wd[15:0] * 32'h0001_0001 : wd;
    g = 1 + gd;
    p = we ? g : g + 1 + rvd;
    err = !mis && p > TMO;
    reqend = mis ? 0 : (g < TMO ? g : TMO);
    done_n = mis ? 1 : err ? TMO + 1 : p + 1;
    done_at = -1;
    reqcnt = 0;
    be_seen = '0;
    wd_seen = '0;
    @(negedge clk);
    req_valid_M = 1'b1;
    we_M = we;
    funct3_M = f3;
    addr_M = addr;
    wdata_M = wd;
    for (int n = 0; n <= done_n; n++) begin
      inreq = n >= 1 && n <= reqend;
      inwait = !we && !mis && n > reqend && n < done_n;
      mem_gnt = (n == g) || (noise && !inreq && $urandom_range(1) == 1);
      mem_rvalid = (!we && n == p) || (noise && !inwait && $urandom_range(1) == 1);
      mem_rdata = (!we && n == p) ? rd : $urandom;
      #1;
      vectors++;
      if (done !== (n == done_n)) begin
        miscompares++;
        $display("FAIL done cyc=%0d got %b exp %b", n, done, n == done_n);
      end
      vectors++;
      if (stall_M !== (n != done_n)) begin
        miscompares++;
        $display("FAIL stall cyc=%0d got %b exp %b", n, stall_M, n != done_n);
      end
      vectors++;
      if (mem_req !== inreq) begin
        miscompares++;
        $display("FAIL mem_req cyc=%0d got %b exp %b", n, mem_req, inreq);
      end
      if (mem_req === 1'b1) reqcnt++;
      if (done === 1'b1 && done_at < 0) done_at = n;
      if (n == 1 && !mis) begin
        be_seen = mem_be;
        wd_seen = mem_wdata;
        vectors++;
        if (mem_addr !== {addr[31:2], 2'b00}) begin
          miscompares++;
          $display("FAIL mem_addr got %h exp %h", mem_addr, {addr[31:2], 2'b00});
        end
        vectors++;
        if (mem_we !== we) begin
          miscompares++;
          $display("FAIL mem_we got %b exp %b", mem_we, we);
        end
        vectors++;
        if (mem_be !== ebe) begin
          miscompares++;
          $display("FAIL mem_be got %b exp %b", mem_be, ebe);
        end
        if (we) begin
          vectors++;
          if (mem_wdata !== ewd) begin
            miscompares++;
            $display("FAIL mem_wdata got %h exp %h", mem_wdata, ewd);
          end
        end
      end
      if (n == done_n) begin
        if (!we && !mis && !err) exp_rdata = rd;
        if (!we && !mis) begin
          exp_sel = f3;
          exp_off = addr[1:0];
        end
        vectors++;
        if (misalign_exc !== mis) begin
          miscompares++;
          $display("FAIL misalign_exc got %b exp %b", misalign_exc, mis);
        end
        vectors++;
        if (bus_err !== err) begin
          miscompares++;
          $display("FAIL bus_err got %b exp %b", bus_err, err);
        end
        vectors++;
        if (rdata_o !== exp_rdata) begin
          miscompares++;
          $display("FAIL rdata_o got %h exp %h", rdata_o, exp_rdata);
        end
        if (!we && !mis) begin
          vectors++;
          if (load_sel_o !== exp_sel || offset_o !== exp_off) begin
            miscompares++;
            $display("FAIL load_sel/offset got %b/%0d exp %b/%0d", load_sel_o, offset_o, exp_sel, exp_off);
          end
        end
      end
      if (n < done_n) @(negedge clk);
    end
    req_valid_M = 1'b0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid_M = 1'b0;
    we_M = 1'b0;
    funct3_M = '0;
    addr_M = '0;
    wdata_M = '0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_rdata = '0;
    exp_sel = '0;
    exp_off = '0;
    vectors++;
    if ({done, misalign_exc, bus_err, mem_req, mem_we, stall_M} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b exp 000000", {done, misalign_exc, bus_err, mem_req, mem_we, stall_M});
    end
    vectors++;
    if ({rdata_o, load_sel_o, offset_o, mem_addr, mem_be, mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_regs got %h/%b/%0d/%h/%b/%h exp all zero", rdata_o, load_sel_o, offset_o, mem_addr, mem_be, mem_wdata);
    end
  endtask

  task automatic test_lb();
    access(1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_1234, 1'b0);
    vectors++;
    if (done_at !== 3) begin
      miscompares++;
      $display("FAIL lb_latency got %0d exp 3", done_at);
    end
    vectors++;
    if (rdata_o !== 32'h80FF_1234 || load_sel_o !== 3'b000 || offset_o !== 2'd3) begin
      miscompares++;
      $display("FAIL lb_result got %h/%b/%0d exp 80ff1234/000/3", rdata_o, load_sel_o, offset_o);
    end
    vectors++;
    if (mem_addr !== 32'h1000 || be_seen !== 4'b1111) begin
      miscompares++;
      $display("FAIL lb_bus got %h/%b exp 00001000/1111", mem_addr, be_seen);
    end
  endtask

  task automatic test_sb();
    access(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'h0, 1'b0);
    vectors++;
    if (be_seen !== 4'b1000 || wd_seen !== 32'hABAB_ABAB || done_at !== 2) begin
      miscompares++;
      $display("FAIL sb got %b/%h/%0d exp 1000/ababab ab/2", be_seen, wd_seen, done_at);
    end
  endtask

  task automatic test_sh();
    access(1'b1, 3'b001, 32'h0000_2002, 32'h1234_5678, 1, 0, 32'h0, 1'b0);
    vectors++;
    if (be_seen !== 4'b1100 || wd_seen !== 32'h5678_5678) begin
      miscompares++;
      $display("FAIL sh got %b/%h exp 1100/56785678", be_seen, wd_seen);
    end
  endtask

  task automatic test_misalign();
    access(1'b0, 3'b010, 32'h0000_2002, 32'h0, 0, 0, 32'h0, 1'b1);
    vectors++;
    if (done_at !== 1 || reqcnt !== 0) begin
      miscompares++;
      $display("FAIL misalign got done@%0d req=%0d exp done@1 req=0", done_at, reqcnt);
    end
  endtask

  task automatic test_timeout();
    access(1'b0, 3'b010, 32'h0000_0300, 32'h0, 0, 1, 32'hCAFE_F00D, 1'b0);
    access(1'b0, 3'b010, 32'h0000_0304, 32'h0, 9, 0, 32'h1111_1111, 1'b0);
    vectors++;
    if (reqcnt !== TMO || done_at !== TMO + 1 || rdata_o !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL timeout got req=%0d done@%0d rdata=%h exp req=%0d done@%0d rdata=cafef00d",
               reqcnt, done_at, rdata_o, TMO, TMO + 1);
    end
  endtask

  task automatic test_reset_wait();
    @(negedge clk);
    req_valid_M = 1'b1;
    we_M = 1'b0;
    funct3_M = 3'b010;
    addr_M = 32'h40;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst = 1'b1;
    req_valid_M = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_rdata = '0;
    exp_sel = '0;
    exp_off = '0;
    vectors++;
    if (mem_req !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_wait got req=%b done=%b exp 0/0", mem_req, done);
    end
    mem_rvalid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    vectors++;
    if (done !== 1'b0 || rdata_o !== 32'h0 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL stale_rvalid got done=%b rdata=%h req=%b exp 0/0/0", done, rdata_o, mem_req);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || rdata_o !== 32'h0) begin
      miscompares++;
      $display("FAIL stale_rvalid2 got done=%b rdata=%h exp 0/0", done, rdata_o);
    end
  endtask

  task automatic test_back_to_back();
    access(1'b0, 3'b010, 32'h0000_0010, 32'h0, 2, 0, 32'h0BAD_CAFE, 1'b0);
    vectors++;
    if (done_at !== 5) begin
      miscompares++;
      $display("FAIL b2b_first got done@%0d exp 5", done_at);
    end
    access(1'b1, 3'b010, 32'h0000_0014, 32'h7654_3210, 0, 0, 32'h0, 1'b0);
    vectors++;
    if (done_at !== 2 || be_seen !== 4'b1111 || wd_seen !== 32'h7654_3210) begin
      miscompares++;
      $display("FAIL b2b_second got done@%0d be=%b wd=%h exp 2/1111/76543210", done_at, be_seen, wd_seen);
    end
  endtask

  task automatic test_random();
    logic we;
    logic [2:0] f3;
    int gd;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(1));
      f3 = 3'($urandom_range(7));
      if (we && f3[2] && !f3[1]) f3[2] = 1'b0;
      gd = $urandom_range(we ? 4 : 3);
      if (!we && gd == 3) gd = 9;
      access(we, f3, $urandom, $urandom, gd, $urandom_range(2), $urandom, 1'b1);
      if ($urandom_range(3) == 0) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sb();
    test_sh();
    test_misalign();
    test_timeout();
    test_reset_wait();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
